// File: rtl/testbasic23_pair_sink_pkg.sv
// Shared types and constants for the TestBasic23 pair sink.
package testbasic23_types;

  // Sink sequencing: take the unsigned word, then the signed word, then offer the sum.
  typedef enum logic [1:0] {
    sink_read_u = 2'd0,
    sink_read_s = 2'd1,
    sink_write  = 2'd2
  } SinkSections;

  // Limits of the signed 32-bit result range.
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/testbasic23_pair_sink_sat_add.sv
// Combinational unsigned-plus-signed 32-bit adder with optional clamp to the signed range.
module sat_add_u32_s32
  import testbasic23_types::*;
#(
  parameter int SATURATE = 1
) (
  input  logic        [31:0] a,
  input  logic signed [31:0] b,
  output logic        [31:0] sum,
  output logic               sat
);

  logic [33:0] sumWide;
  logic        posOvf;
  logic        negOvf;

  // 34 bits hold every possible u32 + s32 result exactly, so the top three bits
  // agree exactly when the value fits in signed 32 bits.
  assign sumWide = {2'b00, a} + {{2{b[31]}}, b};
  assign posOvf  = ~sumWide[33] & (sumWide[32] | sumWide[31]);
  assign negOvf  =  sumWide[33] & ~(sumWide[32] & sumWide[31]);

  // Pick wrapped low bits or the clamped limit depending on the build option.
  always_comb begin
    sum = sumWide[31:0];
    sat = 1'b0;
    if (SATURATE != 0) begin
      if (posOvf) begin
        sum = INT_MAX;
        sat = 1'b1;
      end else if (negOvf) begin
        sum = INT_MIN;
        sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/testbasic23_pair_sink.sv
// Pair sink: collects an unsigned word then a signed word, emits their (saturated)
// sum on a ready/valid output and counts completed output transfers.
module testbasic23_pair_sink
  import testbasic23_types::*;
#(
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic        [31:0]      b_in,
  input  logic                    b_in_sync,
  output logic                    b_in_notify,
  input  logic signed [31:0]      b_in2,
  input  logic                    b_in2_sync,
  output logic                    b_in2_notify,
  output logic        [31:0]      result_out,
  input  logic                    result_out_sync,
  output logic                    result_out_notify,
  output logic                    sat_out,
  output logic        [CNT_W-1:0] pair_count_out
);

  SinkSections      state_q;
  SinkSections      state_d;
  logic [31:0]      uReg_q;
  logic [31:0]      result_q;
  logic             sat_q;
  logic [CNT_W-1:0] count_q;

  logic             takeU;
  logic             takeS;
  logic             giveResult;
  logic [31:0]      addSum;
  logic             addSat;

  // A transfer needs both the partner's sync and our own notify; notifies come
  // straight from the state register, so no sync input reaches a notify output.
  assign takeU      = b_in_notify       & b_in_sync;
  assign takeS      = b_in2_notify      & b_in2_sync;
  assign giveResult = result_out_notify & result_out_sync;

  sat_add_u32_s32 #(
    .SATURATE(SATURATE)
  ) uSatAdd (
    .a  (uReg_q),
    .b  (b_in2),
    .sum(addSum),
    .sat(addSat)
  );

  // State register; reset drops any partial pair and restarts at the unsigned read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= sink_read_u;
    end else begin
      state_q <= state_d;
    end
  end

  // Advance one section per completed transfer; otherwise hold (this is where backpressure stalls).
  always_comb begin
    state_d = state_q;
    case (state_q)
      sink_read_u: if (takeU)      state_d = sink_read_s;
      sink_read_s: if (takeS)      state_d = sink_write;
      sink_write:  if (giveResult) state_d = sink_read_u;
      default:                     state_d = sink_read_u;
    endcase
  end

  // Exactly one port is offered at a time, decoded from the registered state.
  always_comb begin
    b_in_notify       = 1'b0;
    b_in2_notify      = 1'b0;
    result_out_notify = 1'b0;
    case (state_q)
      sink_read_u: b_in_notify       = 1'b1;
      sink_read_s: b_in2_notify      = 1'b1;
      sink_write:  result_out_notify = 1'b1;
      default:     b_in_notify       = 1'b1;
    endcase
  end

  // Capture operands and result; result/sat only change on the signed-word transfer,
  // so they stay stable for the whole time the output is offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uReg_q   <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      if (takeU) begin
        uReg_q <= b_in;
      end
      if (takeS) begin
        result_q <= addSum;
        sat_q    <= addSat;
      end
      if (giveResult) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign result_out     = result_q;
  assign sat_out        = sat_q;
  assign pair_count_out = count_q;

endmodule

// File: tb/tb_testbasic23_pair_sink.sv
// Bench for the pair sink: three builds (default, wrap-mode, 4-bit counter) share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_testbasic23_pair_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] b_in = '0;
  logic        b_in_sync = 1'b0;
  logic [31:0] b_in2 = '0;
  logic        b_in2_sync = 1'b0;
  logic        result_out_sync = 1'b1;

  logic        dutUNotify, dutSNotify, dutRNotify, dutSat;
  logic [31:0] dutResult;
  logic [15:0] dutCount;
  logic        wrpUNotify, wrpSNotify, wrpRNotify, wrpSat;
  logic [31:0] wrpResult;
  logic [15:0] wrpCount;
  logic        ctrUNotify, ctrSNotify, ctrRNotify, ctrSat;
  logic [31:0] ctrResult;
  logic [3:0]  ctrCount;

  logic [31:0] addA = '0;
  logic [31:0] addB = '0;
  logic [31:0] addSum;
  logic        addSat;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int uCycle      = 0;
  int checksOn    = 0;

  // Model: which word the sink wants next (0=u, 1=s, 2=result offered), and outcome values.
  int          mPhase    = 0;
  longint      mU        = 0;
  logic [31:0] mResSat   = '0;
  logic        mSat      = 1'b0;
  logic [31:0] mResWrap  = '0;
  int          mCount    = 0;

  always #5 clk = ~clk;

  testbasic23_pair_sink #(.SATURATE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(dutUNotify),
    .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(dutSNotify),
    .result_out(dutResult), .result_out_sync(result_out_sync), .result_out_notify(dutRNotify),
    .sat_out(dutSat), .pair_count_out(dutCount));

  testbasic23_pair_sink #(.SATURATE(0), .CNT_W(16)) dutWrap (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(wrpUNotify),
    .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(wrpSNotify),
    .result_out(wrpResult), .result_out_sync(result_out_sync), .result_out_notify(wrpRNotify),
    .sat_out(wrpSat), .pair_count_out(wrpCount));

  testbasic23_pair_sink #(.SATURATE(1), .CNT_W(4)) dutCnt4 (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(ctrUNotify),
    .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(ctrSNotify),
    .result_out(ctrResult), .result_out_sync(result_out_sync), .result_out_notify(ctrRNotify),
    .sat_out(ctrSat), .pair_count_out(ctrCount));

  sat_add_u32_s32 #(.SATURATE(1)) uAdd (
    .a(addA), .b(addB), .sum(addSum), .sat(addSat));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Protocol model: consume words in order, compute the sum with wide arithmetic.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPhase = 0; mU = 0; mResSat = '0; mSat = 1'b0; mResWrap = '0; mCount = 0;
    end else begin
      longint s;
      case (mPhase)
        0: if (b_in_sync) begin mU = longint'(b_in); mPhase = 1; end
        1: if (b_in2_sync) begin
             s = mU + longint'($signed(b_in2));
             mResWrap = s[31:0];
             if (s > 64'sd2147483647) begin mResSat = 32'h7FFFFFFF; mSat = 1'b1; end
             else if (s < -64'sd2147483648) begin mResSat = 32'h80000000; mSat = 1'b1; end
             else begin mResSat = s[31:0]; mSat = 1'b0; end
             mPhase = 2;
           end
        default: if (result_out_sync) begin mCount++; mPhase = 0; end
      endcase
    end
  end

  // Every-cycle comparison of all three builds against the model.
  always @(negedge clk) begin
    if (rst && checksOn != 0) begin
      checkOutput("uNotify",     {31'b0, dutUNotify}, {31'b0, mPhase == 0});
      checkOutput("sNotify",     {31'b0, dutSNotify}, {31'b0, mPhase == 1});
      checkOutput("rNotify",     {31'b0, dutRNotify}, {31'b0, mPhase == 2});
      checkOutput("wrapNotify",  {29'b0, wrpUNotify, wrpSNotify, wrpRNotify},
                  {29'b0, mPhase == 0, mPhase == 1, mPhase == 2});
      checkOutput("cnt4Notify",  {29'b0, ctrUNotify, ctrSNotify, ctrRNotify},
                  {29'b0, mPhase == 0, mPhase == 1, mPhase == 2});
      checkOutput("count",       {16'b0, dutCount}, {16'b0, 16'(mCount)});
      checkOutput("wrapCount",   {16'b0, wrpCount}, {16'b0, 16'(mCount)});
      checkOutput("cnt4Count",   {28'b0, ctrCount}, {28'b0, 4'(mCount)});
      if (mPhase == 2) begin
        checkOutput("result",     dutResult, mResSat);
        checkOutput("sat",        {31'b0, dutSat}, {31'b0, mSat});
        checkOutput("wrapResult", wrpResult, mResWrap);
        checkOutput("wrapSat",    {31'b0, wrpSat}, 32'd0);
        checkOutput("cnt4Result", ctrResult, mResSat);
        checkOutput("cnt4Sat",    {31'b0, ctrSat}, {31'b0, mSat});
      end
    end
  end

  // Wait (bounded) for a notify observed at a falling edge.
  task automatic waitNotify(input int which, input string name);
    int k;
    k = 0;
    while (((which == 0) ? dutUNotify : dutSNotify) !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: notify never rose within 20 cycles", name);
    end
  endtask

  // Present one u word then one s word; returns on the edge where the result is offered.
  task automatic applyStimulus(input logic [31:0] u, input logic [31:0] s);
    waitNotify(0, "waitU");
    uCycle = cyc;
    b_in = u; b_in_sync = 1'b1;
    @(negedge clk);
    b_in_sync = 1'b0;
    waitNotify(1, "waitS");
    b_in2 = s; b_in2_sync = 1'b1;
    @(negedge clk);
    b_in2_sync = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addVec [5][4];
    int firstU;
    logic [15:0] heldCount;

    // Standalone adder vectors: a, b, expected sum, expected sat.
    addVec[0] = '{32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'd1};
    addVec[1] = '{32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'd0};
    addVec[2] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'd0};
    addVec[3] = '{32'h00000000, 32'h80000000, 32'h80000000, 32'd0};
    addVec[4] = '{32'h00000005, 32'hFFFFFFF6, 32'hFFFFFFFB, 32'd0};
    for (int i = 0; i < 5; i++) begin
      addA = addVec[i][0]; addB = addVec[i][1];
      #1;
      checkOutput($sformatf("addSum%0d", i), addSum, addVec[i][2]);
      checkOutput($sformatf("addSat%0d", i), {31'b0, addSat}, addVec[i][3]);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rstUNotify", {31'b0, dutUNotify}, 32'd1);
    checkOutput("rstSNotify", {31'b0, dutSNotify}, 32'd0);
    checkOutput("rstRNotify", {31'b0, dutRNotify}, 32'd0);
    checkOutput("rstResult",  dutResult, 32'd0);
    checkOutput("rstCount",   {16'b0, dutCount}, 32'd0);
    rst = 1'b1;
    checksOn = 1;
    @(negedge clk);

    // Basic pair 13 + -7, then a second pair to measure throughput.
    applyStimulus(32'd13, 32'hFFFFFFF9);
    firstU = uCycle;
    checkOutput("basicResult", dutResult, 32'd6);
    checkOutput("basicSat",    {31'b0, dutSat}, 32'd0);
    @(negedge clk);
    checkOutput("basicNotifyDrop", {31'b0, dutRNotify}, 32'd0);
    checkOutput("basicCount",      {16'b0, dutCount}, 32'd1);
    applyStimulus(32'd13, 32'hFFFFFFF9);
    checkOutput("pairCycles", uCycle - firstU, 32'd3);
    @(negedge clk);

    // Positive saturation, and wrap in the non-saturating build.
    applyStimulus(32'hFFFFFFFF, 32'd5);
    checkOutput("posSatResult", dutResult, 32'h7FFFFFFF);
    checkOutput("posSatFlag",   {31'b0, dutSat}, 32'd1);
    checkOutput("posWrapResult", wrpResult, 32'h00000004);
    checkOutput("posWrapFlag",  {31'b0, wrpSat}, 32'd0);
    @(negedge clk);

    // Negative bound is reachable without clamping.
    applyStimulus(32'd0, 32'h80000000);
    checkOutput("negBoundResult", dutResult, 32'h80000000);
    checkOutput("negBoundSat",    {31'b0, dutSat}, 32'd0);
    @(negedge clk);
    applyStimulus(32'd0, 32'hFFFFFFFF);
    checkOutput("minusOneResult", dutResult, 32'hFFFFFFFF);
    checkOutput("minusOneSat",    {31'b0, dutSat}, 32'd0);
    @(negedge clk);

    // Backpressure: hold the output, keep both producers pushing.
    result_out_sync = 1'b0;
    applyStimulus(32'd7, 32'd8);
    heldCount = dutCount;
    b_in = 32'd999; b_in2 = 32'd555;
    b_in_sync = 1'b1; b_in2_sync = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bpResult",  dutResult, 32'd15);
      checkOutput("bpNotifies", {30'b0, dutUNotify, dutSNotify}, 32'd0);
      checkOutput("bpCount",   {16'b0, dutCount}, {16'b0, heldCount});
    end
    result_out_sync = 1'b1;
    b_in_sync = 1'b0;
    @(negedge clk);
    checkOutput("releaseCount",   {16'b0, dutCount}, {16'b0, heldCount + 16'd1});
    checkOutput("releaseUNotify", {31'b0, dutUNotify}, 32'd1);
    @(negedge clk);
    checkOutput("earlySIgnored",  {31'b0, dutSNotify}, 32'd0);
    b_in2_sync = 1'b0;
    applyStimulus(32'd20, 32'd22);
    checkOutput("afterBpResult", dutResult, 32'd42);
    @(negedge clk);

    // Reset in the middle of a pair.
    waitNotify(0, "waitUMid");
    b_in = 32'd100; b_in_sync = 1'b1;
    @(negedge clk);
    b_in_sync = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstUNotify", {31'b0, dutUNotify}, 32'd1);
    checkOutput("midRstSNotify", {31'b0, dutSNotify}, 32'd0);
    checkOutput("midRstRNotify", {31'b0, dutRNotify}, 32'd0);
    checkOutput("midRstResult",  dutResult, 32'd0);
    checkOutput("midRstSat",     {31'b0, dutSat}, 32'd0);
    checkOutput("midRstCount",   {16'b0, dutCount}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'd1, 32'd2);
    checkOutput("postRstResult", dutResult, 32'd3);
    @(negedge clk);

    // Counter wrap in the 4-bit build: 17 pairs from a clean reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(32'(i * 3), 32'(-i));
      @(negedge clk);
      if (i == 15) checkOutput("cnt4At15", {28'b0, ctrCount}, 32'd15);
      if (i == 16) checkOutput("cnt4At16", {28'b0, ctrCount}, 32'd0);
      if (i == 17) checkOutput("cnt4At17", {28'b0, ctrCount}, 32'd1);
    end
    checkOutput("cnt16At17", {16'b0, dutCount}, 32'd17);

    checksOn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
